// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, operand classes and unpack helper.
package fp_pkg;

  localparam int unsigned FP_EXP_BIAS = 127;
  localparam int unsigned FP_EXP_MAX  = 255;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F800000;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

  typedef struct packed {
    logic      sign;
    logic [7:0] exp;
    logic [23:0] mant;
    fp_class_t cls;
  } fp_unpk_t;

  // Denormals classify as ZERO (flushed); mant carries the hidden 1.
  function automatic fp_unpk_t fp_unpack(input logic [31:0] v);
    fp_unpk_t u;
    u.sign = v[31];
    u.exp  = v[30:23];
    u.mant = {1'b1, v[22:0]};
    if (v[30:23] == 8'd0)
      u.cls = ZERO;
    else if (v[30:23] != 8'(FP_EXP_MAX))
      u.cls = NORM;
    else if (v[22:0] == 23'd0)
      u.cls = INF;
    else
      u.cls = NAN;
    return u;
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: retire a quotient bit, shift the remainder.
module fp_div_step (
  input  logic [24:0] rem_i,
  input  logic [23:0] div_i,
  output logic [24:0] rem_o,
  output logic        q_o
);

  logic [23:0] diff;
  logic [23:0] keep;

  assign q_o   = rem_i >= {1'b0, div_i};
  // When q_o is set the true difference is below the divisor, so 24 bits hold it.
  assign diff  = rem_i[23:0] - div_i;
  assign keep  = q_o ? diff : rem_i[23:0];
  assign rem_o = {keep, 1'b0};

endmodule

// File: rtl/fp_div32_seq.sv
// Multi-cycle IEEE-754 single divider, R quotient bits per cycle.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_div32_seq
  import fp_pkg::*;
#(
  parameter int unsigned R         = 1,
  parameter logic [31:0] NAN_CANON = FP_QNAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned NCYC     = 27 / R;
  localparam logic [4:0]  CNT_LAST = 5'(NCYC - 1);

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [26:0]       quo_q, quo_d;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       dvs_q, dvs_d;
  logic              sgn_q, sgn_d;
  logic signed [9:0] exp_q, exp_d;
  logic [31:0]       res_q, res_d;
  logic [3:0]        flg_q, flg_d;

  fp_unpk_t ua;
  fp_unpk_t ub;
  logic     sgn_in;

  assign ua     = fp_unpack(a);
  assign ub     = fp_unpack(b);
  assign sgn_in = ua.sign ^ ub.sign;

  // Mutually exclusive operand-class decode.
  logic c_nan, c_ainf, c_bzero, c_zero, c_norm;

  assign c_nan   = (ua.cls == NAN) | (ub.cls == NAN)
                 | ((ua.cls == ZERO) & (ub.cls == ZERO))
                 | ((ua.cls == INF) & (ub.cls == INF));
  assign c_ainf  = (ua.cls == INF)
                 & ((ub.cls == ZERO) | (ub.cls == NORM));
  assign c_bzero = (ua.cls == NORM) & (ub.cls == ZERO);
  assign c_zero  = ((ua.cls == ZERO)
                 & ((ub.cls == NORM) | (ub.cls == INF)))
                 | ((ua.cls == NORM) & (ub.cls == INF));
  assign c_norm  = (ua.cls == NORM) & (ub.cls == NORM);

  logic [31:0] sp_res;
  logic [3:0]  sp_flg;

  always_comb begin
    sp_res = NAN_CANON;
    sp_flg = 4'b0000;
    unique case (1'b1)
      c_nan: begin
        sp_res = NAN_CANON;
        sp_flg = 4'b0000;
      end
      c_ainf: begin
        sp_res = {sgn_in, FP_POS_INF[30:0]};
        sp_flg = {sgn_in, 3'b000};
      end
      c_bzero: begin
        sp_res = {sgn_in, FP_POS_INF[30:0]};
        sp_flg = {sgn_in, 3'b001};
      end
      c_zero: begin
        sp_res = {sgn_in, 31'd0};
        sp_flg = {sgn_in, 3'b100};
      end
      default: ;
    endcase
  end

  logic [24:0]  rem_c [0:R];
  logic [R-1:0] qv;

  assign rem_c[0] = rem_q;

  for (genvar k = 0; k < R; k++) begin : g_step
    fp_div_step u_step (
      .rem_i (rem_c[k]),
      .div_i (dvs_q),
      .rem_o (rem_c[k+1]),
      .q_o   (qv[R-1-k])
    );
  end

  logic [23:0]       rd_man;
  logic              rd_g, rd_s, rd_inc;
  logic signed [9:0] rd_e, rd_ef;
  logic [24:0]       rd_sum;
  logic [22:0]       rd_frac;
  logic [31:0]       rd_res;
  logic [3:0]        rd_flg;

  always_comb begin
    if (quo_q[26]) begin
      rd_man = quo_q[26:3];
      rd_g   = quo_q[2];
      rd_s   = (|quo_q[1:0]) | (|rem_q);
      rd_e   = exp_q;
    end else begin
      rd_man = quo_q[25:2];
      rd_g   = quo_q[1];
      rd_s   = quo_q[0] | (|rem_q);
      rd_e   = exp_q - 10'sd1;
    end
`ifdef FP_DIV_ROUND_NEAREST_EN
    rd_inc = rd_g & (rd_s | rd_man[0]);
`else
    rd_inc = 1'b0;
`endif
    rd_sum  = {1'b0, rd_man} + 25'(rd_inc);
    rd_frac = rd_sum[24] ? rd_sum[23:1] : rd_sum[22:0];
    rd_ef   = rd_sum[24] ? rd_e + 10'sd1 : rd_e;
    if (rd_ef >= $signed(10'(FP_EXP_MAX))) begin
      rd_res = {sgn_q, FP_POS_INF[30:0]};
      rd_flg = {sgn_q, 3'b011};
    end else if (rd_ef <= 10'sd0) begin
      rd_res = {sgn_q, 31'd0};
      rd_flg = {sgn_q, 3'b110};
    end else begin
      rd_res = {sgn_q, rd_ef[7:0], rd_frac};
      rd_flg = {sgn_q, 1'b0, rd_g | rd_s, 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    exp_d   = exp_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sgn_d = sgn_in;
          if (c_norm) begin
            state_d = S_DIV;
            cnt_d   = CNT_LAST;
            quo_d   = '0;
            rem_d   = {1'b0, ua.mant};
            dvs_d   = ub.mant;
            exp_d   = {2'b00, ua.exp} - {2'b00, ub.exp}
                    + 10'(FP_EXP_BIAS);
          end else begin
            state_d = S_DONE;
            res_d   = sp_res;
            flg_d   = sp_flg;
          end
        end
      end
      S_DIV: begin
        quo_d = {quo_q[26-R:0], qv};
        rem_d = rem_c[R];
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0)
          state_d = S_ROUND;
      end
      S_ROUND: begin
        res_d   = rd_res;
        flg_d   = rd_flg;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      exp_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign busy   = (state_q == S_DIV) | (state_q == S_ROUND);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign flags  = flg_q;

endmodule

// File: tb/tb_fp_div32_seq.sv
// Scoreboard bench for fp_div32_seq: directed corners plus random operands.
module tb_fp_div32_seq;

  localparam int unsigned R = 1;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_div32_seq #(.R(R)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference: exact long division in 64-bit integers, then round/range.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output int k);
    logic s, xz, yz, xi, yi, xn, yn, g, st;
    longint unsigned num, den, q, rm, mant;
    int lead, e, sh;
    s  = x[31] ^ y[31];
    xz = x[30:23] == 8'd0;
    yz = y[30:23] == 8'd0;
    xi = x[30:23] == 8'hFF && x[22:0] == 23'd0;
    yi = y[30:23] == 8'hFF && y[22:0] == 23'd0;
    xn = x[30:23] == 8'hFF && x[22:0] != 23'd0;
    yn = y[30:23] == 8'hFF && y[22:0] != 23'd0;
    k  = 0;
    f  = 4'b0000;
    r  = 32'h7FC00000;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      r = 32'h7FC00000;
    end else if (xi) begin
      r = {s, 8'hFF, 23'd0};
      f = {s, 3'b000};
    end else if (yz) begin
      r = {s, 8'hFF, 23'd0};
      f = {s, 3'b001};
    end else if (xz || yi) begin
      r = {s, 31'd0};
      f = {s, 3'b100};
    end else begin
      k    = 27 / R + 1;
      num  = {40'd0, 1'b1, x[22:0]} << 39;
      den  = {40'd0, 1'b1, y[22:0]};
      q    = num / den;
      rm   = num % den;
      lead = 0;
      for (int i = 0; i < 64; i++)
        if (q[i]) lead = i;
      sh   = lead - 23;
      mant = q >> sh;
      g    = q[sh-1];
      st   = ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 0) || (rm != 0);
      e    = int'(x[30:23]) - int'(y[30:23]) + 127 + lead - 39;
`ifdef FP_DIV_ROUND_NEAREST_EN
      if (g && (st || mant[0])) mant = mant + 64'd1;
`endif
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = {s, 3'b011};
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = {s, 3'b110};
      end else begin
        r = {s, e[7:0], mant[22:0]};
        f = {s, 1'b0, g | st, 1'b0};
      end
    end
  endfunction

  // Called #1 after a posedge with busy low; returns #1 after the capture edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input logic [3:0] f,
                       input int k);
    exp_t e;
    e.r   = r;
    e.f   = f;
    e.cyc = cyc + 1 + k;
    sb.push_back(e);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic [3:0]  f;
    int          k;
    ref_div(x, y, r, f, k);
    issue(x, y, r, f, k);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int unsigned p;
    v = $urandom;
    p = $urandom_range(0, 99);
    if (p < 3)
      v[30:23] = 8'd0;
    else if (p < 5)
      v[30:0] = {8'hFF, 23'd0};
    else if (p < 6)
      v[30:23] = 8'hFF;
    else if (p < 20)
      v[30:23] = 8'($urandom_range(1, 254));
    else
      v[30:23] = 8'($urandom_range(96, 158));
    return v;
  endfunction

  // Monitor: a completion is done rising, or done held across an accepted start.
  initial begin : monitor
    logic prev_done, prev_acc, have_last;
    exp_t e, last;
    prev_done = 1'b0;
    prev_acc  = 1'b0;
    have_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
        prev_acc  = 1'b0;
        have_last = 1'b0;
      end else begin
        if (done && (!prev_done || prev_acc)) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: result %h with empty scoreboard", result);
          end else begin
            e = sb.pop_front();
            chk("result", result, e.r);
            chk("flags", 32'(flags), 32'(e.f));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            last      = e;
            have_last = 1'b1;
          end
        end else if (done && have_last) begin
          chk("hold_result", result, last.r);
        end
        prev_done = done;
        prev_acc  = start && !busy;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int nb, n;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1;

    // 6/2: latency and busy window
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    nb = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) break;
    end
    chk("busy_cycles", 32'(nb), 32'd28);
    @(posedge clk);
    #1;

`ifdef FP_DIV_ROUND_NEAREST_EN
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0010, 28);
`else
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0010, 28);
`endif
    wait_idle();
    issue(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1001, 0);
    issue(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0000, 0);
    issue(32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0011, 28);
    wait_idle();
    issue(32'h00800000, 32'h40000000, 32'h00000000, 4'b0110, 28);
    wait_idle();

    // start while busy is ignored
    issue(32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 28);
    repeat (4) @(posedge clk);
    #1;
    a     = 32'h3F800000;
    b     = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    // reset mid-operation
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    wait_idle();

    // random operands, back-to-back whenever the unit is free
    for (int i = 0; i < 1500; i++) begin
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      issue_ref(rnd_fp(), rnd_fp());
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
